instr_issuer: RTL and testbench
===============================

// Module: instr_issuer
// PURPOSE
//  Host-side driver for the simple processor: buffers 16-bit instruction words and
//  issues them one at a time on the processor's din/run port. Waits for done
//  after each issue, captures op, and raises a timeout error if done never arrives.
//  Sits between a host/loader and processor (din, run, done, op).
// PARAMETERS
//  DEPTH    8   instruction FIFO entries (power of 2, >=2)
//  TIMEOUT  32  max cycles in WAIT without done before abort (>=2)
// PORTS
//  clk           in   1   rising-edge clock
//  reset         in   1   asynchronous, active-low reset
//  wr_en         in   1   push wr_data into FIFO (ignored when full)
//  wr_data       in   16  instruction word {op[2:0],imm,rX[2:0],imm9/rY}
//  full          out  1   FIFO holds DEPTH entries
//  empty         out  1   FIFO holds 0 entries
//  start         in   1   1-cycle pulse: begin issuing FIFO contents (ignored if busy)
//  busy          out  1   sequence in progress (state != IDLE)
//  din           out  16  instruction to processor
//  run           out  1   1-cycle issue strobe to processor
//  done          in   1   processor completion strobe
//  op            in   16  processor result bus
//  result        out  16  op captured on each accepted done
//  result_valid  out  1   1-cycle pulse, result updated this cycle
//  timeout_err   out  1   sticky; set on WAIT timeout, cleared by accepted start
//  issued_cnt    out  8   instructions completed since last accepted start (wraps 255->0)
// BEHAVIOUR
//  Reset (reset=0, async): FIFO empty, state IDLE; din=0, run=0, result=0,
//   result_valid=0, timeout_err=0, issued_cnt=0, busy=0, empty=1, full=0.
//  FIFO: push when wr_en && !full; pop only on ISSUE entry. Push+pop same cycle
//   allowed when full (count unchanged). Pointers wrap mod DEPTH.
//  FSM states IDLE, ISSUE, WAIT:
//   IDLE : start && !empty -> ISSUE; clear timeout_err, issued_cnt. start && empty ->
//          clear flags, stay IDLE. done ignored.
//   ISSUE: one cycle; din<=FIFO head (popped), run=1 exactly this cycle -> WAIT.
//   WAIT : run=0, din held stable. done=1 -> result<=op, result_valid=1,
//          issued_cnt+1; then ISSUE if !empty else IDLE. Timer counts cycles in
//          WAIT; reaching TIMEOUT without done -> timeout_err=1, IDLE (remaining
//          FIFO entries retained).
//  Latency: run is asserted 1 cycle after start; next run at earliest 1 cycle after
//   done (back-to-back: done at cycle N -> run at N+1).
//  done sampled only in WAIT; done in ISSUE (same cycle as run) ignored.
//  Pushes during busy are legal and are issued within the same sequence.
//  din keeps the last issued word in IDLE (not cleared) until reset.
// STRUCTURE
//  Package issuer_pkg: INSTR_W=16, opcode localparams (MV=3'b000, MVT=3'b001,
//   ADD=3'b010, SUB=3'b011), FSM state encoding.
//  Sub-module instr_fifo (sync FIFO, DEPTH x 16, full/empty, async active-low reset);
//   FSM, timer and capture logic live in instr_issuer.
// TESTING (bench uses a behavioural processor model: done 3 cycles after run, op=sum/diff)
//  1 Push 16'h1a1f,16'h1c0f,16'h4a06; start -> 3 run pulses in order, din matches;
//    last result=16'h002E, issued_cnt=3, empty=1, busy=0.
//  2 Same with 16'h6a06 last -> result=16'h0010; result_valid pulses exactly 3 times.
//  3 Push DEPTH+1 words -> full=1 after DEPTH, extra word dropped; start issues DEPTH.
//  4 Model withholds done -> timeout_err=1 TIMEOUT cycles after run, busy=0, remaining
//    entries kept; next start clears timeout_err and resumes.
//  5 Assert reset low mid-WAIT -> all outputs to reset values immediately, FIFO empty;
//    late done after release ignored.
//  6 start while busy, done during ISSUE, start with empty FIFO -> no extra run, no
//    state change beyond flag clear.

Source files
------------

// File: rtl/issuer_pkg.sv
// Shared constants for the instruction issuer: word width, processor opcodes
// and the issuer FSM state encoding.
package issuer_pkg;

    localparam int INSTR_W = 16;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous instruction FIFO with a combinational head view so the issuer
// can latch the word in the same cycle it pops it.
module instr_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A full FIFO still accepts a write when a slot is freed in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_issuer.sv
// Host-side driver for the simple processor: buffers instruction words and issues
// them one at a time on din/run, waiting for done (with timeout) after each.
module instr_issuer
    import issuer_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               wr_en_i,
    input  logic [INSTR_W-1:0] wr_data_i,
    output logic               full_o,
    output logic               empty_o,
    input  logic               start_i,
    output logic               busy_o,
    output logic [INSTR_W-1:0] din_o,
    output logic               run_o,
    input  logic               done_i,
    input  logic [INSTR_W-1:0] op_i,
    output logic [INSTR_W-1:0] result_o,
    output logic               result_valid_o,
    output logic               timeout_err_o,
    output logic [7:0]         issued_cnt_o
);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    logic [1:0]         state_q, state_d;
    logic [INSTR_W-1:0] din_q, din_d;
    logic [INSTR_W-1:0] result_q, result_d;
    logic               rv_q, rv_d;
    logic               to_q, to_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               pop;
    logic [INSTR_W-1:0] head;
    logic               fifo_empty;
    logic               fifo_full;

    instr_fifo #(
        .DEPTH (DEPTH),
        .W     (INSTR_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (wr_en_i),
        .data_i  (wr_data_i),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        din_d    = din_q;
        result_d = result_q;
        rv_d     = 1'b0;
        to_d     = to_q;
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    to_d  = 1'b0;
                    cnt_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        din_d   = head;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_i) begin
                    result_d = op_i;
                    rv_d     = 1'b1;
                    cnt_d    = cnt_q + 8'd1;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        din_d   = head;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    // Abort leaves the rest of the program queued for a later start.
                    to_d    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            din_q    <= '0;
            result_q <= '0;
            rv_q     <= 1'b0;
            to_q     <= 1'b0;
            cnt_q    <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            din_q    <= din_d;
            result_q <= result_d;
            rv_q     <= rv_d;
            to_q     <= to_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
        end
    end

    assign full_o         = fifo_full;
    assign empty_o        = fifo_empty;
    assign busy_o         = (state_q != ST_IDLE);
    assign run_o          = (state_q == ST_ISSUE);
    assign din_o          = din_q;
    assign result_o       = result_q;
    assign result_valid_o = rv_q;
    assign timeout_err_o  = to_q;
    assign issued_cnt_o   = cnt_q;

endmodule

// File: tb/tb_instr_issuer.sv
// Directed bench for instr_issuer with a behavioural processor that answers
// each run with done three cycles later.
module tb_instr_issuer;
    import issuer_pkg::*;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 32;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        full, empty, start, busy, run, done;
    logic [15:0] din, op, result;
    logic        result_valid, timeout_err;
    logic [7:0]  issued_cnt;

    logic        model_done = 1'b0;
    logic        tb_done;
    logic        model_hold;
    logic [15:0] model_op = 16'h0;
    logic [15:0] m_res;
    logic [15:0] regs [8];
    int          m_cnt = 0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int run_cnt = 0;
    int rv_cnt = 0;
    logic [15:0] din_log [$];
    int          run_cyc [$];

    assign done = model_done | tb_done;
    assign op   = model_op;

    always #5 clk = ~clk;

    instr_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .wr_en_i        (wr_en),
        .wr_data_i      (wr_data),
        .full_o         (full),
        .empty_o        (empty),
        .start_i        (start),
        .busy_o         (busy),
        .din_o          (din),
        .run_o          (run),
        .done_i         (done),
        .op_i           (op),
        .result_o       (result),
        .result_valid_o (result_valid),
        .timeout_err_o  (timeout_err),
        .issued_cnt_o   (issued_cnt)
    );

    task automatic exec(input logic [15:0] w, output logic [15:0] v);
        logic [15:0] src;
        src = w[12] ? {7'b0, w[8:0]} : regs[w[2:0]];
        case (w[15:13])
            OP_MV:   v = src;
            OP_MVT:  v = {w[7:0], regs[w[11:9]][7:0]};
            OP_ADD:  v = regs[w[11:9]] + src;
            OP_SUB:  v = regs[w[11:9]] - src;
            default: v = regs[w[11:9]];
        endcase
        regs[w[11:9]] = v;
    endtask

    // Processor model and output monitor, both sampling on the falling edge.
    always @(negedge clk) begin
        if (run && rst_ni) begin
            if (!model_hold) begin
                exec(din, m_res);
                m_cnt = 3;
            end
            model_done = 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                model_done = 1'b1;
                model_op   = m_res;
            end
        end else begin
            model_done = 1'b0;
        end
        if (rst_ni) begin
            if (run) begin
                run_cnt = run_cnt + 1;
                din_log.push_back(din);
                run_cyc.push_back(cyc);
            end
            if (result_valid) rv_cnt = rv_cnt + 1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input logic [15:0] w);
        wr_en = 1'b1;
        wr_data = w;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy=%b still after %0d cycles, required 0", busy, budget);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks += 9;
        if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (empty !== 1'b1)        begin errors++; $display("FAIL rst_empty: got %b want 1", empty); end
        if (full !== 1'b0)         begin errors++; $display("FAIL rst_full: got %b want 0", full); end
        if (run !== 1'b0)          begin errors++; $display("FAIL rst_run: got %b want 0", run); end
        if (din !== 16'h0)         begin errors++; $display("FAIL rst_din: got %h want 0000", din); end
        if (result !== 16'h0)      begin errors++; $display("FAIL rst_result: got %h want 0000", result); end
        if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_rv: got %b want 0", result_valid); end
        if (timeout_err !== 1'b0)  begin errors++; $display("FAIL rst_to: got %b want 0", timeout_err); end
        if (issued_cnt !== 8'd0)   begin errors++; $display("FAIL rst_cnt: got %0d want 0", issued_cnt); end
        $display("test_reset: done");
    endtask

    task automatic run_program(input string name, input logic [15:0] last_w,
                               input logic [15:0] exp_res);
        int rb, vb;
        logic [15:0] w [3];
        w[0] = 16'h1a1f; w[1] = 16'h1c0f; w[2] = last_w;
        rb = run_cnt; vb = rv_cnt;
        for (int i = 0; i < 3; i++) push(w[i]);
        pulse_start();
        checks++;
        if (run !== 1'b1) begin errors++; $display("FAIL %s_latency: run=%b one cycle after start, want 1", name, run); end
        wait_idle(200);
        checks += 6;
        if (run_cnt - rb !== 3) begin errors++; $display("FAIL %s_runs: got %0d want 3", name, run_cnt - rb); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (din_log[rb+i] !== w[i]) begin errors++; $display("FAIL %s_din%0d: got %h want %h", name, i, din_log[rb+i], w[i]); end
            end
            checks++;
            if (run_cyc[rb+1] - run_cyc[rb] !== 4) begin errors++; $display("FAIL %s_b2b: run spacing %0d want 4", name, run_cyc[rb+1] - run_cyc[rb]); end
        end
        if (result !== exp_res)    begin errors++; $display("FAIL %s_result: got %h want %h", name, result, exp_res); end
        if (issued_cnt !== 8'd3)   begin errors++; $display("FAIL %s_cnt: got %0d want 3", name, issued_cnt); end
        if (empty !== 1'b1)        begin errors++; $display("FAIL %s_empty: got %b want 1", name, empty); end
        if (busy !== 1'b0)         begin errors++; $display("FAIL %s_busy: got %b want 0", name, busy); end
        if (rv_cnt - vb !== 3)     begin errors++; $display("FAIL %s_rvpulses: got %0d want 3", name, rv_cnt - vb); end
        $display("%s: result=%h issued=%0d", name, result, issued_cnt);
    endtask

    task automatic test_full();
        int rb;
        logic [15:0] w;
        rb = run_cnt;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (full !== 1'b0) begin errors++; $display("FAIL full_early%0d: got %b want 0", i, full); end
            w = 16'h1000 | 16'(i << 9) | 16'(i + 1);
            push(w);
        end
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL full_set: got %b want 1", full); end
        push(16'h1fff);
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL full_hold: got %b want 1", full); end
        pulse_start();
        wait_idle(400);
        checks += 4;
        if (run_cnt - rb !== DEPTH) begin errors++; $display("FAIL full_runs: got %0d want %0d", run_cnt - rb, DEPTH); end
        else if (din_log[rb+DEPTH-1] !== 16'h1e08) begin errors++; $display("FAIL full_last_din: got %h want 1e08", din_log[rb+DEPTH-1]); end
        if (result !== 16'h0008)  begin errors++; $display("FAIL full_result: got %h want 0008", result); end
        if (issued_cnt !== 8'd8)  begin errors++; $display("FAIL full_cnt: got %0d want 8", issued_cnt); end
        if (empty !== 1'b1)       begin errors++; $display("FAIL full_empty: got %b want 1", empty); end
        $display("test_full: issued=%0d", issued_cnt);
    endtask

    task automatic test_timeout();
        push(16'h1601);
        push(16'h1655);
        model_hold = 1'b1;
        pulse_start();
        repeat (TIMEOUT) @(posedge clk);
        #1;
        checks += 2;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early: got %b want 0", timeout_err); end
        if (busy !== 1'b1)        begin errors++; $display("FAIL to_busy_early: got %b want 1", busy); end
        @(posedge clk); #1;
        checks += 4;
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_set: got %b want 1", timeout_err); end
        if (busy !== 1'b0)        begin errors++; $display("FAIL to_busy: got %b want 0", busy); end
        if (empty !== 1'b0)       begin errors++; $display("FAIL to_kept: empty=%b want 0", empty); end
        if (issued_cnt !== 8'd0)  begin errors++; $display("FAIL to_cnt: got %0d want 0", issued_cnt); end
        model_hold = 1'b0;
        pulse_start();
        checks += 2;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", timeout_err); end
        if (run !== 1'b1)         begin errors++; $display("FAIL to_resume_run: got %b want 1", run); end
        wait_idle(200);
        checks += 3;
        if (result !== 16'h0055)  begin errors++; $display("FAIL to_resume_result: got %h want 0055", result); end
        if (issued_cnt !== 8'd1)  begin errors++; $display("FAIL to_resume_cnt: got %0d want 1", issued_cnt); end
        if (empty !== 1'b1)       begin errors++; $display("FAIL to_resume_empty: got %b want 1", empty); end
        $display("test_timeout: result=%h", result);
    endtask

    task automatic test_ignored_events();
        int rb, vb;
        rb = run_cnt; vb = rv_cnt;
        push(16'h1203);
        push(16'h1404);
        pulse_start();
        tb_done = 1'b1;
        @(posedge clk); #1;
        tb_done = 1'b0;
        pulse_start();
        wait_idle(200);
        checks += 4;
        if (run_cnt - rb !== 2)   begin errors++; $display("FAIL ign_runs: got %0d want 2", run_cnt - rb); end
        if (rv_cnt - vb !== 2)    begin errors++; $display("FAIL ign_rv: got %0d want 2", rv_cnt - vb); end
        if (issued_cnt !== 8'd2)  begin errors++; $display("FAIL ign_cnt: got %0d want 2", issued_cnt); end
        if (result !== 16'h0004)  begin errors++; $display("FAIL ign_result: got %h want 0004", result); end
        // Leave a sticky timeout with the FIFO drained, then start on empty.
        push(16'h1001);
        model_hold = 1'b1;
        pulse_start();
        wait_idle(200);
        model_hold = 1'b0;
        checks++;
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL ign_to_pre: got %b want 1", timeout_err); end
        rb = run_cnt;
        pulse_start();
        checks += 3;
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL ign_empty_clear: got %b want 0", timeout_err); end
        if (busy !== 1'b0)        begin errors++; $display("FAIL ign_empty_busy: got %b want 0", busy); end
        if (din !== 16'h1001)     begin errors++; $display("FAIL ign_din_hold: got %h want 1001", din); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (run_cnt !== rb)       begin errors++; $display("FAIL ign_empty_run: got %0d runs want 0", run_cnt - rb); end
        $display("test_ignored_events: issued=%0d", issued_cnt);
    endtask

    task automatic test_reset_mid_wait();
        int vb;
        push(16'h1a1f);
        push(16'h1c0f);
        pulse_start();
        @(posedge clk); #1;
        rst_ni = 1'b0;
        #1;
        checks += 6;
        if (busy !== 1'b0)        begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        if (run !== 1'b0)         begin errors++; $display("FAIL mid_run: got %b want 0", run); end
        if (din !== 16'h0)        begin errors++; $display("FAIL mid_din: got %h want 0000", din); end
        if (empty !== 1'b1)       begin errors++; $display("FAIL mid_empty: got %b want 1", empty); end
        if (result !== 16'h0)     begin errors++; $display("FAIL mid_result: got %h want 0000", result); end
        if (issued_cnt !== 8'd0)  begin errors++; $display("FAIL mid_cnt: got %0d want 0", issued_cnt); end
        @(posedge clk); #1;
        rst_ni = 1'b1;
        vb = rv_cnt;
        repeat (6) @(posedge clk);
        #1;
        checks += 3;
        if (rv_cnt !== vb)        begin errors++; $display("FAIL mid_late_done: %0d result pulses want 0", rv_cnt - vb); end
        if (result !== 16'h0)     begin errors++; $display("FAIL mid_late_result: got %h want 0000", result); end
        if (busy !== 1'b0)        begin errors++; $display("FAIL mid_late_busy: got %b want 0", busy); end
        $display("test_reset_mid_wait: done");
    endtask

    initial begin
        rst_ni = 1'b0;
        wr_en = 1'b0; wr_data = 16'h0; start = 1'b0;
        tb_done = 1'b0; model_hold = 1'b0;
        for (int i = 0; i < 8; i++) regs[i] = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_ni = 1'b1;
        @(posedge clk); #1;
        run_program("prog_add", 16'h4a06, 16'h002e);
        run_program("prog_sub", 16'h6a06, 16'h0010);
        test_full();
        test_timeout();
        test_ignored_events();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
